// File: rtl/vlog_fsm_req.sv
// vlog_fsm_req: requester-side client for one port of a req/gnt arbiter.
// Optional re-request on grant timeout is enabled by defining VLOG_FSM_REQ_RETRY_EN.
module vlog_fsm_req #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned TIMEOUT   = 16
`ifdef VLOG_FSM_REQ_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY = 3
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_base,
    input  logic [2:0]        i_gnt,
    output logic [2:0]        o_req,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  REQ_ON  = 3'd1;
    localparam logic [2:0]  REQ_OFF = 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_req;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [DATA_W-1:0]   r_base;
    logic [WAIT_W-1:0]   r_wait_cnt;

    logic w_granted;
    logic w_timeout;
    logic w_last_beat;
    logic w_in_gap;
    logic w_can_retry;

    assign w_granted   = (i_gnt == 3'd1);
    assign w_timeout   = (r_wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign w_last_beat = (r_beat_cnt == (r_len - LEN_W'(1)));

`ifdef VLOG_FSM_REQ_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_gap;

    assign w_in_gap    = r_gap;
    assign w_can_retry = (r_retry_cnt < RETRY_W'(MAX_RETRY));

    // Retry bookkeeping: a one-cycle req gap precedes each re-request window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retry_cnt <= '0;
            r_gap       <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_retry_cnt <= '0;
                r_gap       <= 1'b0;
            end
        end else if (r_state == S_REQ) begin
            if (r_gap) begin
                r_gap <= 1'b0;
            end else if (!w_granted && w_timeout && w_can_retry) begin
                r_gap       <= 1'b1;
                r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
            end
        end
    end
`else
    assign w_in_gap    = 1'b0;
    assign w_can_retry = 1'b0;
`endif

    // Main request/transfer/release sequencer with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= REQ_OFF;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_base       <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_done       <= 1'b0;
            r_dout_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_len != '0) begin
                            r_len      <= i_len;
                            r_base     <= i_base;
                            r_req      <= REQ_ON;
                            r_wait_cnt <= '0;
                            r_state    <= S_REQ;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (w_in_gap) begin
                        r_req      <= REQ_ON;
                        r_wait_cnt <= '0;
                    end else if (w_granted) begin
                        r_beat_cnt <= '0;
                        r_state    <= S_XFER;
                    end else if (w_timeout) begin
                        r_req <= REQ_OFF;
                        if (!w_can_retry) begin
                            r_err   <= 1'b1;
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_XFER: begin
                    // Without grant the beat counter holds and req stays up.
                    if (w_granted) begin
                        r_dout       <= r_base + DATA_W'(r_beat_cnt);
                        r_dout_valid <= 1'b1;
                        r_beat_cnt   <= r_beat_cnt + LEN_W'(1);
                        if (w_last_beat) begin
                            r_req   <= REQ_OFF;
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!w_granted) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= REQ_OFF;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req        = r_req;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_vlog_fsm_req.sv
// tb_vlog_fsm_req: randomized scoreboard bench for vlog_fsm_req with a model arbiter.
module tb_vlog_fsm_req;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned MAX_RETRY = 3;
`ifdef VLOG_FSM_REQ_RETRY_EN
    localparam int unsigned WINDOWS = MAX_RETRY + 1;
`else
    localparam int unsigned WINDOWS = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [DATA_W-1:0] base = '0;
    logic [2:0]        gnt;
    logic [2:0]        req;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              done;
    logic              err;

    logic              arb_en = 1'b1;
    logic              arb_gnt;
    logic              force_off = 1'b0;
    logic [2:0]        force_val = 3'd0;
    logic              rand_glitch = 1'b0;
    logic              rand_force = 1'b0;
    logic [2:0]        rand_val = 3'd0;

    int vectors = 0;
    int miscompares = 0;

    beat_t             beat_q[$];
    logic              done_q[$];
    logic [DATA_W-1:0] last_exp = '0;

    vlog_fsm_req dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .i_base       (base),
        .i_gnt        (gnt),
        .o_req        (req),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    // Model arbiter: grants one cycle after seeing req, overridable by glitches.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) arb_gnt <= 1'b0;
        else        arb_gnt <= arb_en && (req == 3'd1);
    end

    assign gnt = force_off  ? force_val :
                 rand_force ? rand_val  :
                 (arb_gnt ? 3'd1 : 3'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] non_grant();
        logic [2:0] g;
        g = 3'($urandom_range(1, 7));
        if (g == 3'd1) g = 3'd0;
        return g;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            rand_force = rand_glitch && ($urandom_range(0, 3) == 0);
            rand_val   = non_grant();
        end
    end

    // Scoreboard monitor: pops expected beats/completions as the DUT presents them.
    initial begin
        beat_t b;
        logic  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_exp = '0;
            end else begin
                if (dout_valid) begin
                    check("beat_expected", 32'(beat_q.size() > 0), 32'd1);
                    if (beat_q.size() > 0) begin
                        b = beat_q.pop_front();
                        check("dout", 32'(dout), 32'(b.data));
                        last_exp = b.data;
                        if (b.last) check("req_after_last", 32'(req), 32'd0);
                    end
                end else begin
                    check("dout_hold", 32'(dout), 32'(last_exp));
                end
                if (done) begin
                    check("done_expected", 32'(done_q.size() > 0), 32'd1);
                    if (done_q.size() > 0) begin
                        e = done_q.pop_front();
                        check("err", 32'(err), 32'(e));
                        check("beats_left_at_done", 32'(beat_q.size()), 32'd0);
                    end
                end
            end
        end
    end

    task automatic launch(input int l, input logic [DATA_W-1:0] b, input logic exp_err, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            beat_q.push_back({DATA_W'(int'(b) + i), (i == nbeats - 1)});
        end
        done_q.push_back(exp_err);
        start = 1'b1;
        len   = LEN_W'(l);
        base  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int poke_at);
        int n;
        n = 0;
        while (!done && n < budget) begin
            if (n == poke_at) begin
                start = 1'b1;
                len   = LEN_W'($urandom_range(1, 15));
                base  = DATA_W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!dout_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 32'(dout_valid), 32'd1);
    endtask

    initial begin
        int hi;
        int win;
        logic prev;
        int n;
        int l;

        // Reset state
        @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job
        launch(4, 8'h10, 1'b0, 4);
        check("basic_req_raised", 32'(req), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        wait_done(100, -1);
        check("basic_idle", 32'(busy), 32'd0);

        // Zero length
        launch(0, 8'h55, 1'b0, 0);
        check("zero_req_e1", 32'(req), 32'd0);
        check("zero_done_e1", 32'(done), 32'd0);
        @(negedge clk);
        check("zero_done_e2", 32'(done), 32'd1);
        check("zero_req_e2", 32'(req), 32'd0);
        @(negedge clk);

        // Timeout with no grant
        arb_en = 1'b0;
        launch(2, 8'h20, 1'b1, 0);
        hi = 0; win = 1; prev = 1'b1; n = 0;
        while (!done && n < 400) begin
            if (req == 3'd1) begin
                hi++;
                if (!prev) win++;
            end
            prev = (req == 3'd1);
            @(negedge clk);
            n++;
        end
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_req_cycles", 32'(hi), 32'(TIMEOUT * WINDOWS));
        check("timeout_windows", 32'(win), 32'(WINDOWS));
        @(negedge clk);
        arb_en = 1'b1;

        // Preemption after first beat
        launch(3, 8'h40, 1'b0, 3);
        wait_valid(50);
        force_off = 1'b1;
        force_val = non_grant();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("preempt_valid", 32'(dout_valid), 32'd0);
            check("preempt_req", 32'(req), 32'd1);
        end
        force_off = 1'b0;
        wait_done(100, -1);

        // Wrap and ignored start
        launch(3, 8'hFE, 1'b0, 3);
        wait_valid(50);
        start = 1'b1;
        len   = 4'd5;
        base  = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, -1);
        repeat (6) @(negedge clk);
        check("ignored_start_idle", 32'(busy), 32'd0);
        check("ignored_start_no_done", 32'(done_q.size()), 32'd0);

        // Async reset mid-transfer
        launch(15, 8'h80, 1'b0, 15);
        wait_valid(50);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(req), 32'd0);
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        beat_q.delete();
        done_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(1, 8'h33, 1'b0, 1);
        wait_done(100, -1);

        // Randomized jobs with grant glitches and stray start pulses
        rand_glitch = 1'b1;
        for (int j = 0; j < 30; j++) begin
            l = int'($urandom_range(0, 15));
            launch(l, DATA_W'($urandom), 1'b0, l);
            wait_done(400, int'($urandom_range(0, 10)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_glitch = 1'b0;
        repeat (4) @(negedge clk);
        check("final_queues_empty", 32'(beat_q.size() + done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vlog_fsm_req.md
Name: vlog_fsm_req

Overview:
- Requester-side client for the two-port req/gnt arbiter FSM; one instance per arbiter port, driving that port's `req_*` and consuming its `gnt_*`.
- Accepts a local transfer job of `len` beats and raises `req`, waiting for grant with a timeout.
- While granted, streams incrementing data beats, then releases `req` and waits for the arbiter to drop `gnt`.
- Reports completion or error with a one-cycle `done` pulse.

Parameters:
- DATA_W, 8, width of beat data.
- LEN_W, 4, width of job length (max 2^LEN_W-1 beats).
- TIMEOUT, 16, cycles spent in REQ without grant before timeout (>=2).
- MAX_RETRY, 3, re-request attempts after timeout (only with VLOG_FSM_REQ_RETRY_EN).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job launch pulse; sampled only in IDLE.
- len  in  LEN_W  beat count for job; sampled with start.
- base  in  DATA_W  first beat value; sampled with start.
- gnt  in  3  grant from arbiter; granted iff gnt==3'd1.
- req  out  3  request to arbiter; 3'd1 = requesting, 3'd0 = idle; registered.
- dout  out  DATA_W  beat data; registered.
- dout_valid  out  1  beat strobe, one per transferred beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 = timeout abort, 0 = success.

Behaviour:
- Reset (asserted low, async): state=IDLE; req=0, dout=0, dout_valid=0, busy=0, done=0, err=0; all counters=0.
- Reset mid-operation returns to IDLE immediately. No done pulse; the job is lost.
- States: IDLE, REQ, XFER, RELEASE, DONE. All outputs are registered.
- IDLE:
  - start=1 and len!=0: latch len/base; req<=3'd1; wait_cnt<=0; ->REQ.
  - start=1 and len==0: ->DONE with err=0. req is never raised.
- REQ:
  - req held 3'd1.
  - gnt==3'd1: beat_cnt<=0; ->XFER.
  - Otherwise wait_cnt++. When wait_cnt reaches TIMEOUT-1 without grant: req<=0; err<=1; ->RELEASE.
- XFER, each cycle with gnt==3'd1:
  - dout<=base+beat_cnt (mod 2^DATA_W); dout_valid<=1; beat_cnt++.
  - On the beat where beat_cnt==len-1: req<=0 in the same edge; ->RELEASE.
- XFER with gnt!=3'd1 (preemption or arbiter glitch): dout_valid<=0, req stays 3'd1, beat_cnt holds; resume when grant returns. No timeout in XFER.
- RELEASE: req=0. Stay until gnt!=3'd1, then ->DONE. If gnt already !=3'd1 on entry, leave after 1 cycle.
- DONE: done<=1 for exactly one cycle with err; ->IDLE. err clears on the next start.
- start outside IDLE is ignored; no queuing.
- Grant latency: arbiter registers gnt one cycle after sampling req. First beat appears no earlier than 2 edges after req rises.
- dout holds its last value when dout_valid=0.

Optional Feature:
- Macro: VLOG_FSM_REQ_RETRY_EN.
- Defined: on timeout in REQ, if retry_cnt<MAX_RETRY, drop req to 0 for exactly one cycle, then re-raise it, reset wait_cnt, retry_cnt++, and stay in REQ. Only after MAX_RETRY failed retries does it take the timeout path (err=1). retry_cnt clears on start. The retry count is visible only through timing; no extra ports.
- Undefined: first timeout goes directly to RELEASE with err=1. No retry counter exists.

Test Plan:
- Basic job: reset, start with len=4, base=8'h10; tie gnt to a model arbiter that grants after 1 cycle. Expect:
  - req=3'd1 in the cycle after start;
  - dout_valid for 4 cycles with dout 10,11,12,13;
  - req=0 after the 4th beat;
  - done=1, err=0 once gnt drops.
- Zero length: start, len=0. Expect done=1, err=0 two edges later; req stays 0 throughout.
- Timeout: start, len=2, gnt held 0. Expect:
  - without macro: req=3'd1 for TIMEOUT (16) cycles, then 0; done=1, err=1; no dout_valid;
  - with macro: 4 request windows separated by 1-cycle req=0 gaps, then done=1, err=1.
- Preemption: len=3; after beat 1 force gnt=0 for 3 cycles, then restore. Expect dout_valid=0 during the gap, req held 3'd1, beats 2-3 continue at base+1 and base+2, done=1, err=0.
- Wrap and ignored start: base=8'hFE, len=3; pulse start again during XFER. Expect dout FE,FF,00, exactly one done, and the second start ignored.
- Async reset: assert reset mid-XFER, asynchronous to clock. Expect req, dout_valid, busy all 0 immediately and no done pulse; after release, a new start with len=1 completes normally.
